// File: rtl/adc_sample_ctrl.sv
// ADC sample controller: one SPI ADC conversion per rising edge of sample_clk; word presented with a 1-cycle valid.
// Latency: sample_valid is registered at edge CONV_CYCLES+2*DATA_W*SCLK_DIV after the sample edge (68 with defaults).
// Backpressure: none; a sample edge while busy is dropped and sets sticky overrun. Define ADC_TWOS_COMP_EN to invert the word MSB.
module adc_sample_ctrl #(
  parameter int DATA_W      = 16,
  parameter int CONV_CYCLES = 4,
  parameter int SCLK_DIV    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_clk,
  input  logic              adc_miso,
  input  logic              overrun_clr,
  output logic              adc_cnv,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int HP_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CC_W  = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(SCLK_DIV - 1);
  localparam logic [CC_W-1:0]  CC_LAST  = CC_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  generate
    if (DATA_W < 2 || CONV_CYCLES < 1 || SCLK_DIV < 1) begin : g_bad_param
      $error("adc_sample_ctrl: DATA_W must be >= 2, CONV_CYCLES and SCLK_DIV >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            state;
  logic              sc_prev;
  logic              start;
  logic [CC_W-1:0]   conv_cnt;
  logic [HP_W-1:0]   hp_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] load_word;

  assign start = sample_clk & ~sc_prev;

`ifdef ADC_TWOS_COMP_EN
  // Offset-binary to two's complement is just an MSB flip.
  assign load_word = {~shift_reg[DATA_W-1], shift_reg[DATA_W-2:0]};
`else
  assign load_word = shift_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sc_prev      <= 1'b1;
      conv_cnt     <= '0;
      hp_cnt       <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      adc_cnv      <= 1'b0;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sc_prev      <= sample_clk;
      sample_valid <= 1'b0;

      // A set on the same cycle as a clear must win, so the set comes last.
      if (overrun_clr) begin
        overrun <= 1'b0;
      end
      if (start && state != IDLE) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= CONV;
            adc_cnv  <= 1'b1;
            busy     <= 1'b1;
            conv_cnt <= '0;
          end
        end

        CONV: begin
          if (conv_cnt == CC_LAST) begin
            state     <= SHIFT;
            adc_cnv   <= 1'b0;
            adc_cs_n  <= 1'b0;
            hp_cnt    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else begin
            conv_cnt <= conv_cnt + CC_W'(1);
          end
        end

        SHIFT: begin
          if (hp_cnt == HP_LAST) begin
            hp_cnt   <= '0;
            adc_sclk <= ~adc_sclk;
            if (!adc_sclk) begin
              shift_reg <= {shift_reg[DATA_W-2:0], adc_miso};
              bit_cnt   <= bit_cnt + BIT_W'(1);
            end else if (bit_cnt == BIT_LAST) begin
              // Falling edge after the last bit closes the frame.
              state        <= IDLE;
              sample_data  <= load_word;
              sample_valid <= 1'b1;
              adc_cs_n     <= 1'b1;
              busy         <= 1'b0;
            end
          end else begin
            hp_cnt <= hp_cnt + HP_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          adc_cnv  <= 1'b0;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Bench for adc_sample_ctrl: table of ADC words run through a clk/128 sample clock,
// plus hand sequences for timing, overrun and mid-transfer reset. Expected words are queued at stimulus time.
module tb_adc_sample_ctrl;

  localparam int DATA_W      = 16;
  localparam int CONV_CYCLES = 4;
  localparam int SCLK_DIV    = 2;
  localparam int N_EDGE      = CONV_CYCLES + 2 * DATA_W * SCLK_DIV;
  localparam int PERIOD      = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_clk;
  logic              adc_miso = 1'b0;
  logic              overrun_clr;
  logic              adc_cnv;
  logic              adc_cs_n;
  logic              adc_sclk;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              busy;
  logic              overrun;

  adc_sample_ctrl #(
    .DATA_W      (DATA_W),
    .CONV_CYCLES (CONV_CYCLES),
    .SCLK_DIV    (SCLK_DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_clk   (sample_clk),
    .adc_miso     (adc_miso),
    .overrun_clr  (overrun_clr),
    .adc_cnv      (adc_cnv),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // ADC model: first bit after CS falls, next bit on every SCLK falling edge.
  logic [DATA_W-1:0] adc_word = '0;
  logic [DATA_W-1:0] adc_sh = '0;
  int                adc_idx = 0;
  bit                in_xfer = 1'b0;

  always @(negedge adc_sclk or negedge adc_cs_n or posedge adc_cs_n) begin
    if (adc_cs_n !== 1'b0) begin
      in_xfer = 1'b0;
    end else if (!in_xfer) begin
      in_xfer  = 1'b1;
      adc_sh   = adc_word;
      adc_idx  = DATA_W - 1;
      adc_miso = adc_sh[adc_idx];
    end else if (adc_idx > 0) begin
      adc_idx  = adc_idx - 1;
      adc_miso = adc_sh[adc_idx];
    end
  end

  typedef struct {
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] exp_raw;
    logic [DATA_W-1:0] exp_tc;
  } vec_t;

  vec_t              tbl[4];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_word;
  int                errors = 0;
  int                checks = 0;
  int                valid_cnt = 0;

  function automatic logic [DATA_W-1:0] pick(input logic [DATA_W-1:0] raw, input logic [DATA_W-1:0] tc);
`ifdef ADC_TWOS_COMP_EN
    return tc;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clk cycle; outputs are observed on the falling edge, where the scoreboard pops.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (sample_valid === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: sample_data=%h with no conversion pending", sample_data);
      end else begin
        exp_word = exp_q.pop_front();
        check("sample_data", 32'(sample_data), 32'(exp_word));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cnv"},     32'(adc_cnv),      32'd0);
    check({tag, "_cs_n"},    32'(adc_cs_n),     32'd1);
    check({tag, "_sclk"},    32'(adc_sclk),     32'd0);
    check({tag, "_data"},    32'(sample_data),  32'd0);
    check({tag, "_valid"},   32'(sample_valid), 32'd0);
    check({tag, "_busy"},    32'(busy),         32'd0);
    check({tag, "_overrun"}, 32'(overrun),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bad_cnv, bad_cs, bad_sclk, bad_busy, bad_vld, rises, cnt, vk, v0;
    bit  prev_sclk, e_cnv, e_cs, e_sclk, e_busy, e_vld;

    tbl[0] = '{word: 16'h0001, exp_raw: 16'h0001, exp_tc: 16'h8001};
    tbl[1] = '{word: 16'hFFFF, exp_raw: 16'hFFFF, exp_tc: 16'h7FFF};
    tbl[2] = '{word: 16'h8000, exp_raw: 16'h8000, exp_tc: 16'h0000};
    tbl[3] = '{word: 16'h7FFF, exp_raw: 16'h7FFF, exp_tc: 16'hFFFF};

    rst_n       = 1'b0;
    sample_clk  = 1'b1;
    overrun_clr = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // sample_clk already high at reset release must not start a conversion.
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (adc_cnv !== 1'b0 || busy !== 1'b0) cnt++;
    end
    check("no_start_on_high_release", 32'(cnt), 32'd0);
    sample_clk = 1'b0;
    repeat (3) tick();

    // Single conversion, cycle-by-cycle profile.
    adc_word = 16'hA5C3;
    exp_q.push_back(pick(16'hA5C3, 16'h25C3));
    v0 = valid_cnt;
    bad_cnv = 0; bad_cs = 0; bad_sclk = 0; bad_busy = 0; bad_vld = 0; rises = 0;
    prev_sclk = 1'b0;
    sample_clk = 1'b1;
    for (int k = 0; k <= N_EDGE + 4; k++) begin
      tick();
      e_cnv  = (k < CONV_CYCLES);
      e_cs   = !(k >= CONV_CYCLES && k < N_EDGE);
      e_sclk = (k >= CONV_CYCLES && k < N_EDGE && ((k - CONV_CYCLES) % (2 * SCLK_DIV)) >= SCLK_DIV);
      e_busy = (k < N_EDGE);
      e_vld  = (k == N_EDGE);
      if (adc_cnv !== e_cnv) bad_cnv++;
      if (adc_cs_n !== e_cs) bad_cs++;
      if (adc_sclk !== e_sclk) bad_sclk++;
      if (busy !== e_busy) bad_busy++;
      if (sample_valid !== e_vld) bad_vld++;
      if (adc_sclk === 1'b1 && !prev_sclk) rises++;
      prev_sclk = (adc_sclk === 1'b1);
      if (k == 40) sample_clk = 1'b0;
    end
    check("cnv_profile_bad_cycles",   32'(bad_cnv),  32'd0);
    check("cs_n_profile_bad_cycles",  32'(bad_cs),   32'd0);
    check("sclk_profile_bad_cycles",  32'(bad_sclk), 32'd0);
    check("busy_profile_bad_cycles",  32'(bad_busy), 32'd0);
    check("valid_profile_bad_cycles", 32'(bad_vld),  32'd0);
    check("sclk_pulses",              32'(rises),    32'(DATA_W));
    check("single_valid_count",       32'(valid_cnt - v0), 32'd1);

    // Table-driven: sample_clk as a clk/128 divider, one word per period.
    for (int p = 0; p < 4; p++) begin
      adc_word = tbl[p].word;
      exp_q.push_back(pick(tbl[p].exp_raw, tbl[p].exp_tc));
      v0 = valid_cnt;
      vk = -1;
      sample_clk = 1'b1;
      for (int j = 0; j < PERIOD; j++) begin
        tick();
        if (sample_valid === 1'b1 && vk < 0) vk = j;
        if (j == PERIOD / 2 - 1) sample_clk = 1'b0;
      end
      check($sformatf("period%0d_valid_cycle", p), 32'(vk), 32'(N_EDGE));
      check($sformatf("period%0d_valid_count", p), 32'(valid_cnt - v0), 32'd1);
    end
    check("divider_overrun", 32'(overrun), 32'd0);

    // Extra edge during SHIFT: flag set, in-flight word unchanged, nothing queued.
    adc_word = 16'h3C5A;
    exp_q.push_back(pick(16'h3C5A, 16'hBC5A));
    v0 = valid_cnt;
    vk = -1;
    sample_clk = 1'b1;
    for (int k = 0; k <= 140; k++) begin
      tick();
      if (sample_valid === 1'b1 && vk < 0) vk = k;
      if (k == 2) sample_clk = 1'b0;
      if (k == 20) sample_clk = 1'b1;
      if (k == 21) begin
        check("overrun_set_in_shift", 32'(overrun), 32'd1);
        sample_clk = 1'b0;
      end
    end
    check("overrun_inflight_valid_cycle", 32'(vk), 32'(N_EDGE));
    check("overrun_no_queued_conv", 32'(valid_cnt - v0), 32'd1);

    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Sample edge landing exactly on the completing edge is an overrun too.
    adc_word = 16'h1234;
    exp_q.push_back(pick(16'h1234, 16'h9234));
    cnt = 0;
    sample_clk = 1'b1;
    for (int k = 0; k <= 80; k++) begin
      tick();
      if (k == 2) sample_clk = 1'b0;
      if (k == N_EDGE - 1) sample_clk = 1'b1;
      if (k == N_EDGE) begin
        check("overrun_at_edge_n", 32'(overrun), 32'd1);
        check("busy_low_at_edge_n", 32'(busy), 32'd0);
      end
      if (k == N_EDGE + 2) sample_clk = 1'b0;
      if (k > N_EDGE && adc_cnv !== 1'b0) cnt++;
    end
    check("no_conv_after_edge_n", 32'(cnt), 32'd0);

    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_cleared_again", 32'(overrun), 32'd0);

    // Clear and new overrun on the same cycle: the set wins.
    adc_word = 16'h0F0F;
    exp_q.push_back(pick(16'h0F0F, 16'h8F0F));
    sample_clk = 1'b1;
    for (int k = 0; k <= N_EDGE + 4; k++) begin
      tick();
      if (k == 2) sample_clk = 1'b0;
      if (k == 20) begin
        sample_clk  = 1'b1;
        overrun_clr = 1'b1;
      end
      if (k == 21) begin
        check("overrun_set_beats_clear", 32'(overrun), 32'd1);
        sample_clk  = 1'b0;
        overrun_clr = 1'b0;
      end
    end

    // Reset during bit 7 of SHIFT: immediate return to reset values, no valid.
    adc_word = 16'hC3C3;
    v0 = valid_cnt;
    sample_clk = 1'b1;
    for (int k = 0; k <= 35; k++) begin
      tick();
      if (k == 2) sample_clk = 1'b0;
    end
    check("sclk_high_before_reset", 32'(adc_sclk), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("midreset_no_valid", 32'(valid_cnt - v0), 32'd0);

    adc_word = 16'h5AA5;
    exp_q.push_back(pick(16'h5AA5, 16'hDAA5));
    v0 = valid_cnt;
    vk = -1;
    sample_clk = 1'b1;
    for (int k = 0; k <= N_EDGE + 8; k++) begin
      tick();
      if (sample_valid === 1'b1 && vk < 0) vk = k;
      if (k == 2) sample_clk = 1'b0;
    end
    check("post_reset_valid_cycle", 32'(vk), 32'(N_EDGE));
    check("post_reset_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_sample_ctrl.md
Name: adc_sample_ctrl

Overview:
- Consumes the divided sample clock (clk/128) from the clock divider and runs one SPI ADC conversion per sample period.
- On each rising edge of the sample clock: pulses the ADC convert line, shifts in DATA_W bits MSB-first, then presents the word with a one-cycle valid strobe.
- The output feeds the noise-cancelling datapath.

Parameters:
- DATA_W, 16: ADC word width in bits.
- CONV_CYCLES, 4: width of the adc_cnv high pulse, in clk cycles.
- SCLK_DIV, 2: clk cycles per adc_sclk half-period; adc_sclk = clk/(2*SCLK_DIV).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_clk  in  1  divided sample clock from the clock divider; same clock domain, no synchroniser.
- adc_miso  in  1  ADC serial data.
- overrun_clr  in  1  one-cycle clear of the overrun flag.
- adc_cnv  out  1  ADC convert-start pulse.
- adc_cs_n  out  1  ADC chip select, active-low.
- adc_sclk  out  1  SPI clock, idle low.
- sample_data  out  DATA_W  last completed sample; holds until the next sample completes.
- sample_valid  out  1  one-cycle strobe when sample_data updates.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  sticky flag: a sample edge arrived while busy.

Behaviour:
- Reset (async, rst_n low):
  - Outputs: adc_cnv=0, adc_cs_n=1, adc_sclk=0, sample_data=0, sample_valid=0, busy=0, overrun=0.
  - State = IDLE.
  - sc_prev (registered copy of sample_clk) = 1, so a sample_clk that is already high at reset release does not start a conversion.
  - Reset mid-transfer aborts immediately; no partial data is ever presented.
- Edge detect: start = sample_clk & ~sc_prev. sc_prev updates every cycle.
- State machine IDLE -> CONV -> SHIFT -> IDLE. Edge 0 is the clk edge at which start is true in IDLE.
- IDLE -> CONV at edge 0:
  - adc_cnv <= 1, busy <= 1.
  - Cycle counter cleared.
- CONV:
  - adc_cnv stays high for exactly CONV_CYCLES cycles.
  - At edge CONV_CYCLES: adc_cnv <= 0, adc_cs_n <= 0, state <= SHIFT.
  - Half-period counter and bit counter cleared; shift register cleared.
- SHIFT:
  - Half-period counter runs 0..SCLK_DIV-1; at terminal count adc_sclk toggles.
  - On each low->high toggle: shift_reg <= {shift_reg[DATA_W-2:0], adc_miso} (adc_miso sampled at that clk edge); bit_cnt increments.
  - On the high->low toggle that occurs with bit_cnt == DATA_W: sample_data <= shift_reg, sample_valid <= 1, adc_cs_n <= 1, busy <= 0, state <= IDLE.
  - This is edge N = CONV_CYCLES + 2*DATA_W*SCLK_DIV, which is 68 with defaults.
- sample_valid:
  - High for exactly one cycle; never high while in reset.
  - Next possible assertion is one sample period later.
- Overrun:
  - start while state != IDLE (including at edge N) sets overrun <= 1. That edge is ignored; no conversion is queued.
  - overrun_clr clears the flag. A set on the same cycle as a clear wins.
- Width rule: bit_cnt is $clog2(DATA_W+1) bits wide; the half-period counter is $clog2(SCLK_DIV) bits wide, minimum 1.
- Defaults fit inside one clk/128 sample period: 68 < 128 cycles.

Optional Feature:
- Macro ADC_TWOS_COMP_EN.
- When defined: sample_data loads with its MSB inverted (offset-binary to two's-complement). Example: 16'h8000 -> 16'h0000 and 16'h0000 -> 16'h8000.
- When undefined: sample_data is the raw shifted word.
- Timing is identical in both cases.

Test Plan:
- Reset release with sample_clk already high -> no adc_cnv pulse, busy=0 until the next rising edge of sample_clk.
- Single conversion, defaults, adc_miso driven with 16'hA5C3 MSB-first and changed on adc_sclk falling edges:
  - adc_cnv high for 4 cycles from edge 0.
  - 16 adc_sclk pulses, 4 clk cycles per period.
  - sample_valid one cycle after edge 68, sample_data=16'hA5C3.
  - adc_cs_n low only during SHIFT.
- sample_clk driven from the clk/128 divider for 3 periods with data 16'h0001, 16'hFFFF, 16'h8000 -> three sample_valid pulses 128 cycles apart, correct words, overrun stays 0.
- Extra sample_clk rising edge injected during SHIFT -> overrun=1 and the in-flight sample completes unchanged. Then overrun_clr -> overrun=0. overrun_clr on the same cycle as a new overrun -> overrun stays 1.
- rst_n asserted at bit 7 of SHIFT -> all outputs return to reset values at once, sample_valid never pulses. A fresh sample edge afterwards converts normally.
- With ADC_TWOS_COMP_EN defined, input 16'h8000 -> sample_data=16'h0000; input 16'h7FFF -> sample_data=16'hFFFF.
